pet_action_scheduler: RTL
=========================

Name: pet_action_scheduler

Overview:
Sequences raw, debounced user buttons into timed, mutually exclusive command levels for the central pet FSM (sleep, awake, feed, play, test). It sits between the button front-end and the central FSM. It captures button presses as pending requests, arbitrates among them, holds one grant for a programmable time, and enforces a cooldown between grants. It also gates test-mode entry and exit behind a long press.

Parameters:
HOLD_MS, 3, tick_ms pulses a sleep/awake/feed grant is held
PLAY_MAX_MS, 8, maximum tick_ms pulses a play grant may be extended while giro=1
COOLDOWN_MS, 2, tick_ms pulses after a grant during which nothing is granted
LONG_MS, 5, consecutive tick_ms pulses btn_test must be held to enter or leave TEST

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
tick_ms  in  1  one-clk strobe, 1 ms time base
btn_sleep  in  1  debounced level
btn_awake  in  1  debounced level
btn_feed  in  1  debounced level
btn_play  in  1  debounced level
btn_test  in  1  debounced level
giro  in  1  rotation sensor level; extends play
test_sel  in  4  test scenario code
cmd_sleep  out  1  grant level to FSM
cmd_awake  out  1  grant level to FSM
cmd_feed  out  1  grant level to FSM
cmd_play  out  1  grant level to FSM
cmd_test  out  1  high for the whole time in TEST
test_code  out  4  registered test_sel while in TEST, else 0
busy  out  1  high in GRANT, COOLDOWN, TEST
pending  out  4  pending bits {play, sleep, feed, awake}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. While rst=0, on every clk edge all outputs, pending bits, edge registers and counters go to 0 and the state goes to IDLE. Reset mid-grant or mid-TEST drops every cmd_* to 0 on the next clk edge.
- Request capture: a rising edge (registered previous value vs. current) on btn_awake, btn_feed, btn_sleep or btn_play sets its pending bit. Capture happens in IDLE, GRANT and COOLDOWN. It does not happen in TEST_ARM or TEST. A bit that is already set stays set; repeat presses do not queue. The bit is cleared on the cycle its grant starts.
- Sleep/play conflict: if pending sleep and pending play are both 1 when IDLE arbitrates, both are cleared and no grant is issued that cycle.
- Arbitration: IDLE arbitrates every clk cycle. Fixed priority is awake > feed > sleep > play. A request captured on cycle N is arbitrated on cycle N+1. Its cmd_* goes high on the edge ending cycle N+1.
- States:
  - IDLE: if any pending bit is set → GRANT with the selected cmd_* high and the counter cleared. Else, if btn_test=1 → TEST_ARM with the counter cleared.
  - GRANT: exactly one cmd_* is high. The counter increments on tick_ms. For sleep/awake/feed, when counter==HOLD_MS-1 and tick_ms=1 → COOLDOWN with cmd_* low. For play, exit the same way at HOLD_MS, unless giro=1, in which case play continues until giro=0 (exit at the next tick_ms) or counter==PLAY_MAX_MS-1.
  - COOLDOWN: all cmd_* are low. On the tick_ms that brings the counter to COOLDOWN_MS → IDLE. A request captured on that same cycle is serviced on the following IDLE cycle.
  - TEST_ARM: btn_test=0 at any point → IDLE. If btn_test stays 1 for LONG_MS tick_ms pulses → TEST, which clears all pending bits.
  - TEST: cmd_test=1 and test_code<=test_sel every clk. A falling then rising btn_test starts an exit count. If btn_test is held LONG_MS ticks → COOLDOWN with cmd_test=0 and test_code=0.
- Counter: the counter saturates; it never wraps. Its width is $clog2 of the largest parameter, plus 1.
- Simultaneous events: an edge arriving on the same cycle a grant for the same source starts leaves that bit cleared; the grant wins. Zero or one cmd_* is high at any time.
- busy is a registered decode of the state.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: arbitration among awake/feed/sleep/play is round-robin. Priority starts just after the last granted source; the pointer resets to awake. The sleep/play conflict rule still applies.
- Undefined: fixed priority awake > feed > sleep > play.

Test Plan:
- Reset: hold rst=0 for 3 clk with all buttons at 1 → all outputs 0 and pending=0. Release rst → no grant issued, because levels held high through reset produce no rising edge.
- Basic grant: pulse btn_feed for 1 clk → cmd_feed rises 2 clk later and stays high for exactly 3 tick_ms. busy stays high for 5 tick_ms total, then drops.
- Priority and queueing: press feed and awake in the same cycle → awake granted first. Feed is granted 1 clk after COOLDOWN ends, and pending shows feed=1 in between.
- Conflict: press sleep and play in the same cycle while idle → no cmd_* asserted, and pending returns to 0 after 1 clk.
- Play extension: grant play with giro=1 held → cmd_play lasts 8 tick_ms (PLAY_MAX_MS). Repeat with giro falling after 4 ticks → cmd_play drops at tick 5.
- Test mode: hold btn_test for 5 ticks with test_sel=4'd6 → cmd_test=1 and test_code=6. Pressing feed is ignored. Release, then hold btn_test 5 ticks → cmd_test=0, then COOLDOWN, then IDLE. Releasing btn_test at tick 4 of TEST_ARM → back to IDLE with cmd_test never asserted.

Source files
------------

// File: rtl/pet_action_scheduler.sv
// pet_action_scheduler: turns debounced button presses into timed, mutually
// exclusive command levels for the central pet FSM.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin arbitration when defined,
// fixed priority awake > feed > sleep > play otherwise).
module pet_action_scheduler #(
   parameter int HOLD_MS     = 3,
   parameter int PLAY_MAX_MS = 8,
   parameter int COOLDOWN_MS = 2,
   parameter int LONG_MS     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_ms,
   input  logic       btn_sleep,
   input  logic       btn_awake,
   input  logic       btn_feed,
   input  logic       btn_play,
   input  logic       btn_test,
   input  logic       giro,
   input  logic [3:0] test_sel,
   output logic       cmd_sleep,
   output logic       cmd_awake,
   output logic       cmd_feed,
   output logic       cmd_play,
   output logic       cmd_test,
   output logic [3:0] test_code,
   output logic       busy,
   output logic [3:0] pending
);

   localparam int MAX_AB  = (HOLD_MS > PLAY_MAX_MS) ? HOLD_MS : PLAY_MAX_MS;
   localparam int MAX_CD  = (COOLDOWN_MS > LONG_MS) ? COOLDOWN_MS : LONG_MS;
   localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   // Source indices inside the request/grant vectors: {play, sleep, feed, awake}
   localparam int IDX_SLEEP = 2;
   localparam int IDX_PLAY  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_COOLDOWN,
      S_TEST_ARM,
      S_TEST
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [3:0]    pend_reg, pend_next;
   logic [3:0]    prev_reg;
   logic [3:0]    cmd_reg, cmd_next;
   logic          primed_reg;
   logic          rel_reg, rel_next;
   logic          cmd_test_reg;
   logic [3:0]    code_reg;
   logic          busy_reg;
   logic [3:0]    btn_vec;
   logic [3:0]    rises;
   logic          capture;
   logic          conflict;
   logic          win_valid;
   logic [1:0]    win_idx;
   logic          grant_done;

   assign btn_vec  = {btn_play, btn_sleep, btn_feed, btn_awake};
   // primed_reg masks the first cycle after reset so levels held through
   // reset are not mistaken for fresh presses.
   assign rises    = primed_reg ? (btn_vec & ~prev_reg) : 4'd0;
   assign capture  = (state_reg == S_IDLE) || (state_reg == S_GRANT) ||
                     (state_reg == S_COOLDOWN);
   assign conflict = pend_reg[IDX_SLEEP] & pend_reg[IDX_PLAY];
   assign cnt_inc  = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_reg, ptr_next;
   logic [1:0] rr_idx;

   // Round-robin pick: search starts at ptr_reg, the slot after the last grant
   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      rr_idx    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         rr_idx = ptr_reg + 2'(k);
         if (pend_reg[rr_idx]) begin
            win_valid = 1'b1;
            win_idx   = rr_idx;
         end
      end
   end
`else
   // Fixed-priority pick: lowest index (awake) wins
   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pend_reg[i]) begin
            win_valid = 1'b1;
            win_idx   = 2'(i);
         end
      end
   end
`endif

   // Grant-end condition: fixed hold for most sources, giro-extended for play
   always_comb begin
      if (cmd_reg[IDX_PLAY]) begin
         grant_done = (cnt_reg == CW'(PLAY_MAX_MS - 1)) ||
                      ((cnt_reg >= CW'(HOLD_MS - 1)) && !giro);
      end else begin
         grant_done = (cnt_reg == CW'(HOLD_MS - 1));
      end
   end

   // Next-state, counter, pending and grant decode
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg | (capture ? rises : 4'd0);
      cmd_next   = cmd_reg;
      rel_next   = rel_reg;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_next   = ptr_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            cmd_next = 4'd0;
            if (conflict) begin
               // Contradictory sleep+play requests cancel each other
               pend_next[IDX_SLEEP] = 1'b0;
               pend_next[IDX_PLAY]  = 1'b0;
            end else if (win_valid) begin
               state_next         = S_GRANT;
               cmd_next[win_idx]  = 1'b1;
               pend_next[win_idx] = 1'b0;
               cnt_next           = '0;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_next           = win_idx + 2'd1;
`endif
            end else if (btn_test) begin
               state_next = S_TEST_ARM;
               cnt_next   = '0;
            end
         end
         S_GRANT: begin
            if (tick_ms) begin
               if (grant_done) begin
                  state_next = S_COOLDOWN;
                  cmd_next   = 4'd0;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         S_COOLDOWN: begin
            cmd_next = 4'd0;
            if (tick_ms) begin
               if (cnt_reg == CW'(COOLDOWN_MS - 1)) begin
                  state_next = S_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         S_TEST_ARM: begin
            cmd_next = 4'd0;
            if (!btn_test) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else if (tick_ms) begin
               if (cnt_reg == CW'(LONG_MS - 1)) begin
                  state_next = S_TEST;
                  cnt_next   = '0;
                  pend_next  = 4'd0;
                  rel_next   = 1'b0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         S_TEST: begin
            cmd_next = 4'd0;
            // Exit needs a release first, then a fresh long hold
            if (!btn_test) begin
               rel_next = 1'b1;
               cnt_next = '0;
            end else if (rel_reg && tick_ms) begin
               if (cnt_reg == CW'(LONG_MS - 1)) begin
                  state_next = S_COOLDOWN;
                  cnt_next   = '0;
                  rel_next   = 1'b0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
            cmd_next   = 4'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         pend_reg     <= 4'd0;
         prev_reg     <= 4'd0;
         cmd_reg      <= 4'd0;
         primed_reg   <= 1'b0;
         rel_reg      <= 1'b0;
         cmd_test_reg <= 1'b0;
         code_reg     <= 4'd0;
         busy_reg     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_reg      <= 2'd0;
`endif
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         pend_reg     <= pend_next;
         prev_reg     <= btn_vec;
         cmd_reg      <= cmd_next;
         primed_reg   <= 1'b1;
         rel_reg      <= rel_next;
         cmd_test_reg <= (state_next == S_TEST);
         code_reg     <= (state_next == S_TEST) ? test_sel : 4'd0;
         busy_reg     <= (state_next == S_GRANT) || (state_next == S_COOLDOWN) ||
                         (state_next == S_TEST);
`ifdef ARB_ROUND_ROBIN_EN
         ptr_reg      <= ptr_next;
`endif
      end
   end

   assign cmd_awake = cmd_reg[0];
   assign cmd_feed  = cmd_reg[1];
   assign cmd_sleep = cmd_reg[2];
   assign cmd_play  = cmd_reg[3];
   assign cmd_test  = cmd_test_reg;
   assign test_code = code_reg;
   assign busy      = busy_reg;
   assign pending   = pend_reg;

endmodule
